crossbar_slave_mem: RTL

Slave-side responder for the 2-master/2-slave crossbar's req/ack bus. It terminates one crossbar slave port, accepts single-word read and write requests, and pulses `ack` after a fixed, parameterised wait. Reads return `rdata` and writes commit to an internal word-addressed memory. It serves as the synthesisable slave model for crossbar system benches and as a small scratchpad in real designs.

---
 rtl/crossbar_slave_mem.sv | 130 +++++++++++++
 1 files changed

// File: rtl/crossbar_slave_mem.sv
// Crossbar slave responder: single-word read/write into a small memory with a fixed wait before ack.
// Optional CROSSBAR_SLAVE_ERR_EN adds the err output and out-of-range address checking.
module crossbar_slave_mem #(
    parameter int ADDR_W      = 4,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        cmd,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata
`ifdef CROSSBAR_SLAVE_ERR_EN
    ,
    output logic        err
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;

    localparam int          DEPTH     = 2 ** ADDR_W;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [31:0] OOR_DATA  = 32'hDEADBEEF;

    state_t              state;
    logic [3:0]          cnt;
    logic                cmd_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [31:0]         wdata_q;
    logic                oor_q;
    logic [31:0]         mem [DEPTH];

    logic                in_oor;
    logic                cur_cmd;
    logic [ADDR_W-1:0]   cur_idx;
    logic [31:0]         cur_wdata;
    logic                cur_oor;
    logic                enter_ack;
    logic                unused_addr;

    // Bit 31 is the crossbar's slave select; upper index bits only matter for the range check.
    assign unused_addr = ^addr[31:ADDR_W];

`ifdef CROSSBAR_SLAVE_ERR_EN
    assign in_oor = |addr[30:ADDR_W];
`else
    assign in_oor = 1'b0;
`endif

    // With WAIT_CYCLES=0 the capture edge is also the commit edge, so use the live inputs.
    always_comb begin
        cur_cmd   = cmd_q;
        cur_idx   = idx_q;
        cur_wdata = wdata_q;
        cur_oor   = oor_q;
        if (state == IDLE) begin
            cur_cmd   = cmd;
            cur_idx   = addr[ADDR_W-1:0];
            cur_wdata = wdata;
            cur_oor   = in_oor;
        end
        enter_ack = ((state == IDLE) && req && (WAIT_CYCLES == 0)) ||
                    ((state == WAIT) && (cnt == 4'd1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            cmd_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            oor_q   <= 1'b0;
            ack     <= 1'b0;
            rdata   <= 32'h0;
`ifdef CROSSBAR_SLAVE_ERR_EN
            err     <= 1'b0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
        end else begin
            ack <= enter_ack;
`ifdef CROSSBAR_SLAVE_ERR_EN
            err <= enter_ack && cur_oor;
`endif
            if (enter_ack) begin
                if (cur_cmd) begin
                    if (!cur_oor) begin
                        mem[cur_idx] <= cur_wdata;
                    end
                end else begin
                    rdata <= cur_oor ? OOR_DATA : mem[cur_idx];
                end
            end

            case (state)
                IDLE: begin
                    if (req) begin
                        cmd_q   <= cmd;
                        idx_q   <= addr[ADDR_W-1:0];
                        wdata_q <= wdata;
                        oor_q   <= in_oor;
                        cnt     <= WAIT_INIT;
                        state   <= (WAIT_CYCLES == 0) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= ACK;
                    end
                end
                ACK: begin
                    state <= HOLD;
                end
                HOLD: begin
                    // Require a req-low gap so a held request is served only once.
                    if (!req) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
